// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Runs a 4-approach junction (M1, MT, M2, S) through three green phases:
//   MAIN (M1+M2), TURN (M1+MT) and SIDE (S). Each phase change passes
//   through a yellow and then an all-red clearance. Emergency requests can
//   preempt the normal cycle, with a fixed priority order. All timing
//   advances on an external 1 s tick strobe.
//   Lamp encoding: 3'b001 green, 3'b010 yellow, 3'b100 red.
//
//   Optional feature macro: PED_REQ_EN (pedestrian-gated SIDE phase).
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous reset, active low
//   tick      in   1-cycle timing strobe
//   emg_req   in   [3:0] level requests: [0]=M1 [1]=M2 [2]=MT [3]=S
//   ped_req   in   pedestrian button pulse (used only with PED_REQ_EN)
//   light_M1  out  [2:0] lamp M1
//   light_MT  out  [2:0] lamp MT
//   light_M2  out  [2:0] lamp M2
//   light_S   out  [2:0] lamp S
//   phase     out  [1:0] current (GREEN) or target (YELLOW/ALLRED) phase
//   emg_gnt   out  [3:0] one-hot grant while the served phase is green
//   ped_walk  out  walk signal (SIDE green; tied low without PED_REQ_EN)
module traffic_phase_scheduler #(
  parameter int unsigned TW       = 4,
  parameter int unsigned T_MAIN   = 7,
  parameter int unsigned T_TURN   = 5,
  parameter int unsigned T_SIDE   = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_AR     = 1,
  parameter int unsigned T_MINGRN = 2,
  parameter int unsigned T_EMG    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] emg_req,
  input  logic       ped_req,
  output logic [2:0] light_M1,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2,
  output logic [2:0] light_S,
  output logic [1:0] phase,
  output logic [3:0] emg_gnt,
  output logic       ped_walk
);

  typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED} state_e;
  typedef enum logic [1:0] {PH_MAIN = 2'd0, PH_TURN = 2'd1, PH_SIDE = 2'd2} phase_e;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic [TW-1:0] D_MAIN   = TW'(T_MAIN);
  localparam logic [TW-1:0] D_TURN   = TW'(T_TURN);
  localparam logic [TW-1:0] D_SIDE   = TW'(T_SIDE);
  localparam logic [TW-1:0] D_YEL    = TW'(T_YEL);
  localparam logic [TW-1:0] D_AR     = TW'(T_AR);
  localparam logic [TW-1:0] D_MINGRN = TW'(T_MINGRN);
  localparam logic [TW-1:0] D_EMG    = TW'(T_EMG);
  localparam logic [TW-1:0] ONE      = TW'(1);

  state_e        state_q, state_d;
  phase_e        cur_q, cur_d;
  phase_e        nxt_q, nxt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] elapsed_q, elapsed_d;
  logic [3:0]    gnt_q, gnt_d;

  logic          emg_any;
  logic [3:0]    emg_oh;
  phase_e        emg_tgt;
  logic          emg_hit;
  logic          emg_preempt;
  logic          green_entry;
  logic          turn_to_side;

  // Green-approach mask per phase, bit order matches emg_req: M1, M2, MT, S.
  function automatic logic [3:0] green_mask(input phase_e p);
    case (p)
      PH_MAIN: return 4'b0011;
      PH_TURN: return 4'b0101;
      PH_SIDE: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [TW-1:0] green_dur(input phase_e p);
    case (p)
      PH_MAIN: return D_MAIN;
      PH_TURN: return D_TURN;
      PH_SIDE: return D_SIDE;
      default: return D_MAIN;
    endcase
  endfunction

  function automatic phase_e normal_next(input phase_e p, input logic to_side);
    case (p)
      PH_MAIN: return PH_TURN;
      PH_TURN: return to_side ? PH_SIDE : PH_MAIN;
      default: return PH_MAIN;
    endcase
  endfunction

  function automatic logic [2:0] lamp_of(input state_e st, input logic in_cur, input logic in_nxt);
    case (st)
      ST_GREEN:  return in_cur ? LAMP_G : LAMP_R;
      ST_YELLOW: begin
        if (in_cur && in_nxt) return LAMP_G;
        else if (in_cur)      return LAMP_Y;
        else                  return LAMP_R;
      end
      ST_ALLRED: return (in_cur && in_nxt) ? LAMP_G : LAMP_R;
      default:   return LAMP_R;
    endcase
  endfunction

  // Emergency decode: lowest set index wins (M1 > M2 > MT > S).
  always_comb begin
    emg_any = |emg_req;
    emg_oh  = emg_req & (~emg_req + 4'd1);
    emg_tgt = PH_MAIN;
    if (emg_req[0] || emg_req[1]) emg_tgt = PH_MAIN;
    else if (emg_req[2])          emg_tgt = PH_TURN;
    else if (emg_req[3])          emg_tgt = PH_SIDE;
  end

  always_comb begin
    emg_hit     = (state_q == ST_GREEN) && emg_any && (emg_tgt == cur_q);
    emg_preempt = (state_q == ST_GREEN) && emg_any && (emg_tgt != cur_q) &&
                  (elapsed_q >= D_MINGRN);
    green_entry = (state_q == ST_ALLRED) && tick && (timer_q == ONE);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_GREEN;
      cur_q     <= PH_MAIN;
      nxt_q     <= PH_MAIN;
      timer_q   <= D_MAIN;
      elapsed_q <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      timer_q   <= timer_d;
      elapsed_q <= elapsed_d;
      gnt_q     <= gnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    timer_d   = timer_q;
    elapsed_d = elapsed_q;
    gnt_d     = gnt_q;
    case (state_q)
      ST_GREEN: begin
        if (tick && (elapsed_q != '1)) elapsed_d = elapsed_q + ONE;
        // Preemption is checked before normal expiry so it wins a tie.
        if (emg_preempt) begin
          state_d = ST_YELLOW;
          nxt_d   = emg_tgt;
          timer_d = D_YEL;
          gnt_d   = '0;
        end else if (emg_hit) begin
          // Held request keeps the timer pinned at the hold length; once it
          // drops, the same timer counts the hold down and expiry resumes
          // the normal order from cur.
          timer_d = D_EMG;
          gnt_d   = emg_oh;
        end else if (tick) begin
          if (timer_q == ONE) begin
            state_d = ST_YELLOW;
            nxt_d   = normal_next(cur_q, turn_to_side);
            timer_d = D_YEL;
            gnt_d   = '0;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      ST_YELLOW: begin
        if (tick) begin
          if (timer_q == ONE) begin
            state_d = ST_ALLRED;
            timer_d = D_AR;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      ST_ALLRED: begin
        if (green_entry) begin
          state_d   = ST_GREEN;
          cur_d     = nxt_q;
          timer_d   = green_dur(nxt_q);
          elapsed_d = '0;
          gnt_d     = '0;
        end else if (tick) begin
          timer_d = timer_q - ONE;
        end
      end
      default: begin
        state_d = ST_GREEN;
        cur_d   = PH_MAIN;
        timer_d = D_MAIN;
      end
    endcase
  end

  // Output logic
  always_comb begin
    logic [3:0] m_cur;
    logic [3:0] m_nxt;
    m_cur    = green_mask(cur_q);
    m_nxt    = green_mask(nxt_q);
    light_M1 = lamp_of(state_q, m_cur[0], m_nxt[0]);
    light_M2 = lamp_of(state_q, m_cur[1], m_nxt[1]);
    light_MT = lamp_of(state_q, m_cur[2], m_nxt[2]);
    light_S  = lamp_of(state_q, m_cur[3], m_nxt[3]);
    phase    = (state_q == ST_GREEN) ? cur_q : nxt_q;
    emg_gnt  = '0;
    // A live matching request grants combinationally so the grant is
    // visible from the first GREEN cycle; the register covers the hold.
    // Gated by rst so a held request cannot show a grant during reset.
    if ((state_q == ST_GREEN) && rst) emg_gnt = emg_hit ? emg_oh : gnt_q;
  end

`ifdef PED_REQ_EN
  logic ped_pend_q, ped_pend_d;

  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    if (green_entry && (nxt_q == PH_SIDE)) ped_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ped_pend_q <= 1'b0;
    else      ped_pend_q <= ped_pend_d;
  end

  assign turn_to_side = ped_pend_q | (emg_any & (emg_tgt == PH_SIDE));
  assign ped_walk     = (state_q == ST_GREEN) && (cur_q == PH_SIDE);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign turn_to_side   = 1'b1;
  assign ped_walk       = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: table-driven reset/normal-cycle
// vectors plus hand-written sequences for timing, preemption, hold,
// minimum-green, phase lock, pedestrian and mid-operation reset cases.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

`ifdef PED_REQ_EN
  localparam logic PED = 1'b1;
`else
  localparam logic PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] emg_req;
  logic       ped_req;
  logic [2:0] light_M1, light_MT, light_M2, light_S;
  logic [1:0] phase;
  logic [3:0] emg_gnt;
  logic       ped_walk;
  logic [11:0] lamps_w;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        tck;
    logic [3:0]  emg;
    logic        ped;
    logic [11:0] lamps;
    logic [1:0]  ph;
    logic [3:0]  gnt;
    logic        walk;
  } vec_t;

  typedef struct {
    int          c;
    logic [11:0] lamps;
    logic [1:0]  ph;
  } ck_t;

  vec_t tbl[15];
  ck_t  ck[8];

  traffic_phase_scheduler #(
    .TW(4), .T_MAIN(7), .T_TURN(5), .T_SIDE(3), .T_YEL(2),
    .T_AR(1), .T_MINGRN(2), .T_EMG(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .emg_req(emg_req), .ped_req(ped_req),
    .light_M1(light_M1), .light_MT(light_MT), .light_M2(light_M2),
    .light_S(light_S), .phase(phase), .emg_gnt(emg_gnt), .ped_walk(ped_walk)
  );

  assign lamps_w = {light_M1, light_MT, light_M2, light_S};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [11:0] l,
                           input logic [1:0] ph, input logic [3:0] g);
    chk({name, ".lamps"}, 32'(lamps_w), 32'(l));
    chk({name, ".phase"}, 32'(phase), 32'(ph));
    chk({name, ".gnt"}, 32'(emg_gnt), 32'(g));
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 unit later.
  task automatic drive(input logic t, input logic [3:0] e, input logic p);
    tick = t; emg_req = e; ped_req = p;
    #1;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick = 1'b0; emg_req = 4'h0; ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Table: reset release, tick every cycle, MAIN 7 + YEL 2 + AR 1 -> TURN at 10.
    for (int i = 0; i < 15; i++) begin
      tbl[i].tck = 1'b1; tbl[i].emg = 4'h0; tbl[i].ped = 1'b0;
      tbl[i].gnt = 4'h0; tbl[i].walk = 1'b0;
      if (i < 7)       begin tbl[i].lamps = {G, R, G, R}; tbl[i].ph = 2'd0; end
      else if (i < 9)  begin tbl[i].lamps = {G, R, Y, R}; tbl[i].ph = 2'd1; end
      else if (i == 9) begin tbl[i].lamps = {G, R, R, R}; tbl[i].ph = 2'd1; end
      else             begin tbl[i].lamps = {G, G, R, R}; tbl[i].ph = 2'd1; end
    end

    // Checkpoints for tick every 4th clock (ticks on cycles 3, 7, 11 ...).
    ck[0] = '{0,  {G, R, G, R}, 2'd0};
    ck[1] = '{27, {G, R, G, R}, 2'd0};
    ck[2] = '{28, {G, R, Y, R}, 2'd1};
    ck[3] = '{35, {G, R, Y, R}, 2'd1};
    ck[4] = '{36, {G, R, R, R}, 2'd1};
    ck[5] = '{40, {G, G, R, R}, 2'd1};
    ck[6] = '{59, {G, G, R, R}, 2'd1};
    ck[7] = PED ? '{60, {G, Y, R, R}, 2'd0} : '{60, {Y, Y, R, R}, 2'd2};

    // 1. reset values and first transition timing
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].tck, tbl[i].emg, tbl[i].ped);
      chk_state($sformatf("t1[%0d]", i), tbl[i].lamps, tbl[i].ph, tbl[i].gnt);
      chk($sformatf("t1[%0d].walk", i), 32'(ped_walk), 32'(tbl[i].walk));
      next_cyc();
    end

    // 2. durations scale with tick spacing
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      drive((c % 4) == 3, 4'h0, 1'b0);
      for (int k = 0; k < 8; k++)
        if (ck[k].c == c) chk_state($sformatf("t2[c%0d]", c), ck[k].lamps, ck[k].ph, 4'h0);
      next_cyc();
    end

    // 3. MT request in MAIN after 3 ticks -> TURN served, hold T_EMG ticks after drop
    do_reset();
    for (int c = 0; c < 3; c++) begin drive(1'b1, 4'h0, 1'b0); next_cyc(); end
    drive(1'b1, 4'b0100, 1'b0); chk_state("t3.c3", {G, R, G, R}, 2'd0, 4'h0); next_cyc();
    drive(1'b1, 4'b0100, 1'b0); chk_state("t3.c4", {G, R, Y, R}, 2'd1, 4'h0); next_cyc();
    drive(1'b1, 4'b0100, 1'b0); next_cyc();
    drive(1'b1, 4'b0100, 1'b0); chk_state("t3.c6", {G, R, R, R}, 2'd1, 4'h0); next_cyc();
    drive(1'b1, 4'b0100, 1'b0); chk_state("t3.c7", {G, G, R, R}, 2'd1, 4'b0100); next_cyc();
    for (int c = 8; c < 12; c++) begin drive(1'b1, 4'b0100, 1'b0); next_cyc(); end
    drive(1'b1, 4'b0100, 1'b0); chk_state("t3.c12", {G, G, R, R}, 2'd1, 4'b0100); next_cyc();
    for (int c = 13; c < 18; c++) begin drive(1'b1, 4'h0, 1'b0); next_cyc(); end
    drive(1'b1, 4'h0, 1'b0); chk_state("t3.c18", {G, G, R, R}, 2'd1, 4'b0100); next_cyc();
    drive(1'b1, 4'h0, 1'b0);
    if (PED) chk_state("t3.c19", {G, Y, R, R}, 2'd0, 4'h0);
    else     chk_state("t3.c19", {Y, Y, R, R}, 2'd2, 4'h0);
    next_cyc();

    // 4. M1+S during TURN -> M1 served first, then S after M1 drops
    do_reset();
    for (int c = 0; c < 12; c++) begin drive(1'b1, 4'h0, 1'b0); next_cyc(); end
    drive(1'b1, 4'b1001, 1'b0); chk_state("t4.c12", {G, G, R, R}, 2'd1, 4'h0); next_cyc();
    drive(1'b1, 4'b1001, 1'b0); chk_state("t4.c13", {G, Y, R, R}, 2'd0, 4'h0); next_cyc();
    drive(1'b1, 4'b1001, 1'b0); next_cyc();
    drive(1'b1, 4'b1001, 1'b0); chk_state("t4.c15", {G, R, R, R}, 2'd0, 4'h0); next_cyc();
    drive(1'b1, 4'b1001, 1'b0); chk_state("t4.c16", {G, R, G, R}, 2'd0, 4'b0001); next_cyc();
    for (int c = 17; c < 20; c++) begin drive(1'b1, 4'b1001, 1'b0); next_cyc(); end
    drive(1'b1, 4'b1000, 1'b0); chk("t4.c20.lamps", 32'(lamps_w), 32'({G, R, G, R})); next_cyc();
    drive(1'b1, 4'b1000, 1'b0); chk_state("t4.c21", {Y, R, Y, R}, 2'd2, 4'h0); next_cyc();
    drive(1'b1, 4'b1000, 1'b0); next_cyc();
    drive(1'b1, 4'b1000, 1'b0); chk_state("t4.c23", {R, R, R, R}, 2'd2, 4'h0); next_cyc();
    drive(1'b1, 4'b1000, 1'b0); chk_state("t4.c24", {R, R, R, G}, 2'd2, 4'b1000);
    chk("t4.c24.walk", 32'(ped_walk), 32'(PED)); next_cyc();

    // Minimum green, preemption without tick, target locked during clearance
    do_reset();
    drive(1'b1, 4'h0, 1'b0); next_cyc();
    drive(1'b1, 4'b0100, 1'b0); chk_state("mg.c1", {G, R, G, R}, 2'd0, 4'h0); next_cyc();
    drive(1'b0, 4'b0100, 1'b0); chk_state("mg.c2", {G, R, G, R}, 2'd0, 4'h0); next_cyc();
    drive(1'b0, 4'b0001, 1'b0); chk_state("mg.c3", {G, R, Y, R}, 2'd1, 4'h0); next_cyc();
    drive(1'b0, 4'b0001, 1'b0); chk_state("mg.c4", {G, R, Y, R}, 2'd1, 4'h0); next_cyc();
    drive(1'b1, 4'b0001, 1'b0); next_cyc();
    drive(1'b1, 4'b0001, 1'b0); next_cyc();
    drive(1'b1, 4'b0001, 1'b0); chk_state("mg.c7", {G, R, R, R}, 2'd1, 4'h0); next_cyc();
    drive(1'b0, 4'b0001, 1'b0); chk_state("mg.c8", {G, G, R, R}, 2'd1, 4'h0); next_cyc();

    // 5. pedestrian pulse in MAIN -> SIDE taken with walk (SIDE always taken without the feature)
    do_reset();
    for (int c = 0; c < 22; c++) begin
      drive(1'b1, 4'h0, c == 2);
      if (c == 15) chk_state("ped.c15", {Y, Y, R, R}, 2'd2, 4'h0);
      if (c == 17) begin
        chk_state("ped.c17", {R, R, R, R}, 2'd2, 4'h0);
        chk("ped.c17.walk", 32'(ped_walk), 32'(1'b0));
      end
      if (c == 18) begin
        chk_state("ped.c18", {R, R, R, G}, 2'd2, 4'h0);
        chk("ped.c18.walk", 32'(ped_walk), 32'(PED));
      end
      if (c == 21) begin
        chk_state("ped.c21", {R, R, R, Y}, 2'd0, 4'h0);
        chk("ped.c21.walk", 32'(ped_walk), 32'(1'b0));
      end
      next_cyc();
    end

    // 6. asynchronous reset mid-YELLOW with an M1 request held
    do_reset();
    for (int c = 0; c < 7; c++) begin drive(1'b1, 4'h0, 1'b0); next_cyc(); end
    drive(1'b1, 4'b0001, 1'b0); chk_state("t6.yel", {G, R, Y, R}, 2'd1, 4'h0);
    rst = 1'b0;
    #1;
    chk_state("t6.rst", {G, R, G, R}, 2'd0, 4'h0);
    chk("t6.rst.walk", 32'(ped_walk), 32'(1'b0));
    @(negedge clk);
    chk_state("t6.hold", {G, R, G, R}, 2'd0, 4'h0);
    rst = 1'b1;
    drive(1'b1, 4'b0001, 1'b0); chk_state("t6.rel", {G, R, G, R}, 2'd0, 4'b0001); next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
